// File: rtl/ofdm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ofdm_pkg
// Description : Shared constants and FSM state types for OFDM CP removal.
// Revision    : 1.0 - initial release
// ============================================================================
package ofdm_pkg;

    localparam int c_SAMPLE_W               = 32;
    localparam int c_DEF_OFDM_SYMBOL_LENGTH = 80;
    localparam int c_DEF_CP_LENGTH          = 16;
    localparam int c_DEF_FFT_LENGTH         = c_DEF_OFDM_SYMBOL_LENGTH - c_DEF_CP_LENGTH;
    localparam int c_DEF_FFT_LOG2           = $clog2(c_DEF_FFT_LENGTH);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_CP   = 2'd1,
        W_DATA = 2'd2,
        W_DROP = 2'd3
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE   = 1'b0,
        R_STREAM = 1'b1
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/ofdm_pingpong_ram.sv
`default_nettype none
// ============================================================================
// Module      : ofdm_pingpong_ram
// Description : Simple dual-port RAM, one write port, one registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module ofdm_pingpong_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    // Read data only changes on i_rd_en, so it holds during downstream stalls.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ofdm_cp_remove.sv
`default_nettype none
// ============================================================================
// Module      : ofdm_cp_remove
// Description : Strips the cyclic prefix and ping-pong buffers FFT-length symbols.
// Revision    : 1.0 - initial release
// ============================================================================
module ofdm_cp_remove
    import ofdm_pkg::*;
#(
    parameter int OFDM_SYMBOL_LENGTH = c_DEF_OFDM_SYMBOL_LENGTH,
    parameter int CP_LENGTH          = c_DEF_CP_LENGTH,
    parameter int BIT_REVERSE        = 0
) (
    input  logic                  clock_clk,
    input  logic                  reset_reset,
    input  logic [c_SAMPLE_W-1:0] asi_in0_data,
    input  logic                  asi_in0_valid,
    input  logic                  asi_in0_startofpacket,
    input  logic                  asi_in0_endofpacket,
    output logic [c_SAMPLE_W-1:0] aso_out0_data,
    output logic                  aso_out0_valid,
    output logic                  aso_out0_startofpacket,
    output logic                  aso_out0_endofpacket,
    input  logic                  aso_out0_ready,
    output logic                  overflow,
    output logic [7:0]            drop_count
);

    localparam int c_FFT_LEN = OFDM_SYMBOL_LENGTH - CP_LENGTH;
    localparam int c_ADDR_W  = $clog2(c_FFT_LEN);
    localparam int c_CNT_W   = $clog2(OFDM_SYMBOL_LENGTH);
    localparam logic [c_CNT_W-1:0]  c_CP_LEN   = c_CNT_W'(CP_LENGTH);
    localparam logic [c_CNT_W-1:0]  c_CP_LAST  = c_CNT_W'(CP_LENGTH - 1);
    localparam logic [c_CNT_W-1:0]  c_SYM_LAST = c_CNT_W'(OFDM_SYMBOL_LENGTH - 1);
    localparam logic [c_ADDR_W-1:0] c_IDX_LAST = c_ADDR_W'(c_FFT_LEN - 1);

    wr_state_t            r_wstate, w_wstate_nxt;
    rd_state_t            r_rstate, w_rstate_nxt;
    logic [c_CNT_W-1:0]   r_wcnt;
    logic                 r_wbank, r_rbank;
    logic [1:0]           r_full;
    logic                 r_overflow;
    logic [7:0]           r_drop_count;
    logic [c_ADDR_W-1:0]  r_ridx;
    logic                 r_sop, r_eop;
    logic                 w_sop_beat, w_beat, w_wbank_free;
    logic                 w_wr_en, w_commit, w_drop, w_ovf_set;
    logic                 w_accept, w_last_acc, w_start, w_rd_en, w_rd_bank;
    logic [c_ADDR_W-1:0]  w_rd_idx, w_rd_addr_lo, w_wr_addr_lo;
    logic [c_SAMPLE_W-1:0] w_ram_q;

    assign w_sop_beat   = asi_in0_valid && asi_in0_startofpacket;
    assign w_beat       = asi_in0_valid && !asi_in0_startofpacket;
    assign w_wbank_free = !r_full[r_wbank];
    assign w_wr_addr_lo = c_ADDR_W'(r_wcnt - c_CP_LEN);

    // ---------------- write FSM ----------------
    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) r_wstate <= W_IDLE;
        else             r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        if (w_sop_beat) begin
            w_wstate_nxt = w_wbank_free ? W_CP : W_DROP;
        end else if (w_beat) begin
            case (r_wstate)
                W_CP: begin
                    if (asi_in0_endofpacket)       w_wstate_nxt = W_IDLE;
                    else if (r_wcnt == c_CP_LAST)  w_wstate_nxt = W_DATA;
                end
                W_DATA: begin
                    if (r_wcnt == c_SYM_LAST)      w_wstate_nxt = asi_in0_endofpacket ? W_IDLE : W_DROP;
                    else if (asi_in0_endofpacket)  w_wstate_nxt = W_IDLE;
                end
                W_DROP: if (asi_in0_endofpacket)   w_wstate_nxt = W_IDLE;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_wr_en   = 1'b0;
        w_commit  = 1'b0;
        w_drop    = 1'b0;
        w_ovf_set = 1'b0;
        if (w_sop_beat) begin
            w_drop    = (r_wstate == W_CP) || (r_wstate == W_DATA) || !w_wbank_free;
            w_ovf_set = !w_wbank_free;
        end else if (w_beat) begin
            case (r_wstate)
                W_CP: w_drop = asi_in0_endofpacket;
                W_DATA: begin
                    w_wr_en = 1'b1;
                    if (r_wcnt == c_SYM_LAST) begin
                        w_commit = asi_in0_endofpacket;
                        w_drop   = !asi_in0_endofpacket;
                    end else begin
                        w_drop   = asi_in0_endofpacket;
                    end
                end
                default: ;
            endcase
        end
    end

    // The SOP beat is sample 0, so the counter restarts at 1 for the next beat.
    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_wcnt       <= '0;
            r_wbank      <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_sop_beat)  r_wcnt <= c_CNT_W'(1);
            else if (w_beat) r_wcnt <= r_wcnt + c_CNT_W'(1);
            if (w_commit)    r_wbank <= !r_wbank;
            if (w_ovf_set)   r_overflow <= 1'b1;
            if (w_drop && (r_drop_count != 8'hFF)) r_drop_count <= r_drop_count + 8'd1;
        end
    end

    // Writer only ever holds a free bank and reader only a full one, so a
    // commit and a free never target the same bank.
    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) r_full <= 2'b00;
        else r_full <= (r_full & ~{w_last_acc & r_rbank, w_last_acc & !r_rbank})
                     | {w_commit & r_wbank, w_commit & !r_wbank};
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) r_rstate <= R_IDLE;
        else             r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:   if (r_full[r_rbank]) w_rstate_nxt = R_STREAM;
            R_STREAM: if (w_last_acc && !r_full[!r_rbank]) w_rstate_nxt = R_IDLE;
            default:  w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_accept   = (r_rstate == R_STREAM) && aso_out0_ready;
        w_last_acc = w_accept && r_eop;
        w_start    = ((r_rstate == R_IDLE) && r_full[r_rbank]) || (w_last_acc && r_full[!r_rbank]);
        w_rd_en    = w_start || (w_accept && !r_eop);
        w_rd_bank  = w_last_acc ? !r_rbank : r_rbank;
        w_rd_idx   = w_start ? '0 : r_ridx;
    end

    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_rbank <= 1'b0;
            r_ridx  <= '0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
        end else begin
            if (w_last_acc) r_rbank <= !r_rbank;
            if (w_rd_en) begin
                r_ridx <= w_rd_idx + c_ADDR_W'(1);
                r_sop  <= w_start;
                r_eop  <= (w_rd_idx == c_IDX_LAST);
            end
        end
    end

    generate
        if (BIT_REVERSE == 1) begin : g_bitrev
            for (genvar i = 0; i < c_ADDR_W; i++) begin : g_bit
                assign w_rd_addr_lo[i] = w_rd_idx[c_ADDR_W-1-i];
            end
        end else begin : g_linear
            assign w_rd_addr_lo = w_rd_idx;
        end
    endgenerate

    ofdm_pingpong_ram #(
        .DATA_W (c_SAMPLE_W),
        .ADDR_W (c_ADDR_W + 1)
    ) u_ram (
        .clk       (clock_clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr ({r_wbank, w_wr_addr_lo}),
        .i_wr_data (asi_in0_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr ({w_rd_bank, w_rd_addr_lo}),
        .o_rd_data (w_ram_q)
    );

    // RAM output is not reset, so data is forced to zero whenever not valid.
    assign aso_out0_valid         = (r_rstate == R_STREAM);
    assign aso_out0_startofpacket = aso_out0_valid && r_sop;
    assign aso_out0_endofpacket   = aso_out0_valid && r_eop;
    assign aso_out0_data          = aso_out0_valid ? w_ram_q : '0;
    assign overflow               = r_overflow;
    assign drop_count             = r_drop_count;

endmodule
`default_nettype wire

// File: doc/ofdm_cp_remove.md
OFDM_CP_REMOVE -- requirements
Module: ofdm_cp_remove

Interface
REQ-001 The block SHALL have parameter OFDM_SYMBOL_LENGTH, default 80, giving input packet length in samples, cyclic prefix included.
REQ-002 The block SHALL have parameter CP_LENGTH, default 16, giving leading samples discarded per packet; FFT_LENGTH = OFDM_SYMBOL_LENGTH - CP_LENGTH, which SHALL be a power of two.
REQ-003 The block SHALL have parameter BIT_REVERSE, default 0, where 1 selects bit-reversed read order.
REQ-004 The block SHALL have port clock_clk, input, 1 bit, the single clock.
REQ-005 The block SHALL have port reset_reset, input, 1 bit, the reset, asynchronous and active-high.
REQ-006 The block SHALL have port asi_in0_data, input, 32 bits, sample {real[31:16], imag[15:0]}.
REQ-007 The block SHALL have port asi_in0_valid, input, 1 bit, sample qualifier; there is no ready and upstream cannot be stalled.
REQ-008 The block SHALL have ports asi_in0_startofpacket and asi_in0_endofpacket, input, 1 bit each, packet delimiters from symbol sync.
REQ-009 The block SHALL have port aso_out0_data, output, 32 bits, FFT-bound sample.
REQ-010 The block SHALL have ports aso_out0_valid, aso_out0_startofpacket and aso_out0_endofpacket, output, 1 bit each.
REQ-011 The block SHALL have port aso_out0_ready, input, 1 bit, downstream backpressure with ready latency 0.
REQ-012 The block SHALL have port overflow, output, 1 bit, sticky flag set when a packet is dropped for lack of a free bank.
REQ-013 The block SHALL have port drop_count, output, 8 bits, a saturating count of all dropped packets.

Function
REQ-014 The write FSM SHALL have states W_IDLE, W_CP, W_DATA and W_DROP; input beats without asi_in0_valid SHALL be ignored.
REQ-015 In W_IDLE, a valid SOP beat SHALL count as CP sample 0 and enter W_CP if a bank is free; otherwise it SHALL enter W_DROP, set overflow and increment drop_count.
REQ-016 In W_CP, valid beats SHALL be discarded; after CP_LENGTH total beats, including the SOP beat, the FSM SHALL enter W_DATA.
REQ-017 In W_DATA, beats SHALL be written to the selected bank at addresses 0..FFT_LENGTH-1.
REQ-018 A bank SHALL commit (full=1) in the cycle the beat carrying EOP is accepted and that beat is exactly sample OFDM_SYMBOL_LENGTH-1; the FSM SHALL then return to W_IDLE and toggle the write bank.
REQ-019 On a length error, i.e. EOP early, or sample OFDM_SYMBOL_LENGTH-1 without EOP, the packet SHALL be discarded, the bank SHALL stay free, drop_count SHALL increment, and the FSM SHALL enter W_IDLE or W_DROP respectively.
REQ-020 An SOP arriving in W_CP or W_DATA SHALL abandon the current packet, increment drop_count, and restart at CP sample 0.
REQ-021 W_DROP SHALL discard beats until EOP, then enter W_IDLE; an SOP arriving in W_DROP SHALL be handled as in W_IDLE.
REQ-022 The read FSM SHALL have states R_IDLE and R_STREAM; it SHALL leave R_IDLE when the read bank is full, and the first aso_out0_valid SHALL occur 2 cycles after the commit cycle.
REQ-023 In R_STREAM, the read address SHALL advance only on valid&&ready; data, valid, SOP and EOP SHALL hold stable while valid&&!ready.
REQ-024 aso_out0_startofpacket SHALL accompany output index 0 and aso_out0_endofpacket SHALL accompany index FFT_LENGTH-1.
REQ-025 The output address SHALL be the index, or the index bit-reversed over log2(FFT_LENGTH) bits when BIT_REVERSE=1.
REQ-026 The bank SHALL be freed in the cycle the EOP beat is accepted; with a full other bank, valid SHALL stay asserted for back-to-back symbols with no bubble.
REQ-027 A free and a commit of the same bank in the same cycle SHALL be impossible; a free of one bank and a commit of the other in the same cycle SHALL both take effect.
REQ-028 Sustained throughput SHALL be one output per cycle while aso_out0_ready=1.
REQ-029 Samples SHALL pass unmodified with no arithmetic applied.
REQ-030 drop_count SHALL saturate at 255.

Reset
REQ-031 Asserting reset_reset, including mid-packet, SHALL immediately clear aso_out0_valid, aso_out0_startofpacket, aso_out0_endofpacket, overflow, drop_count, and both full flags.
REQ-032 Asserting reset_reset SHALL set aso_out0_data to 0, both FSMs to W_IDLE and R_IDLE, and both bank pointers to 0.
REQ-033 RAM contents SHALL NOT be reset.

Structure
REQ-034 Package ofdm_pkg SHALL hold OFDM_SYMBOL_LENGTH and CP_LENGTH defaults, the FFT_LENGTH and log2 constants, and the write and read FSM state enumerations.
REQ-035 Sub-module ofdm_pingpong_ram SHALL be a simple dual-port RAM of 2*FFT_LENGTH x 32 with one write port, one registered read port and no reset.

Verification
REQ-036 Scenario 1: one 80-beat packet carrying samples 0..79 with ready=1 -> output is 64 beats of values 16..79, SOP on 16, EOP on 79, drop_count=0.
REQ-037 Scenario 2: three back-to-back packets with ready=0 until all have arrived -> the third packet is dropped, overflow=1, drop_count=1, and the first two symbols then stream intact.
REQ-038 Scenario 3: a packet with EOP on beat 70, then a good packet -> drop_count=1 and only the good symbol is output.
REQ-039 Scenario 4: ready toggling randomly at 50% -> no sample is lost or duplicated and data is stable while stalled.
REQ-040 Scenario 5: BIT_REVERSE=1 with input data equal to beat index -> output order is 16+bitrev6(k).
REQ-041 Scenario 6: reset asserted at beat 40 of the first packet, then a clean packet -> all outputs are 0 during reset and the clean symbol is output correctly.
